register_file_mp: RTL

Parametrised multi-port register file with configurable data width, depth and read-port count, registered reads, write-to-read bypass and a per-register busy scoreboard for pipeline hazard tracking. It is the successor to the fixed 32x32, two-read/one-write register file. It sits between decode (read/reserve) and writeback (write) in the pipelined datapath.

---
 rtl/register_file_mp_pkg.sv | 33 +++
 rtl/register_file_mp_scoreboard.sv | 58 +++++
 rtl/register_file_mp.sv | 94 +++++++++
 3 files changed

// File: rtl/register_file_mp_pkg.sv
// Shared defaults, busy-bit update encoding and address qualification for register_file_mp.
// ZERO_REG_EN: when defined, register 0 is hardwired to zero and never marked busy.
`default_nettype none

package register_file_mp_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_DEPTH    = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_NUM_READ = 2;

  // Value returned on a read of an address that has no backing register.
  localparam int OOR_READ_VALUE = 0;

  typedef enum logic [1:0] {
    BUSY_HOLD  = 2'd0,
    BUSY_CLEAR = 2'd1,
    BUSY_SET   = 2'd2
  } busy_op_e;

  // True when addr names a real, writable register.
  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth);
    logic ok;
    ok = (addr < depth);
`ifdef ZERO_REG_EN
    ok = ok && (addr != 32'd0);
`endif
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/register_file_mp_scoreboard.sv
// reg_scoreboard: per-register busy bits; reset clears all, a write clears one, a reserve sets one.
// A same-cycle reserve beats a write to the same register. ZERO_REG_EN masks register 0.
`default_nettype none

module reg_scoreboard
  import register_file_mp_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_sel,
  input  logic [ADDR_W-1:0] sel_write,
  input  logic              reserve_sel,
  input  logic [ADDR_W-1:0] sel_reserve,
  output logic [DEPTH-1:0]  busy_next_o
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  busy_op_e         op [DEPTH];
  logic             write_ok;
  logic             reserve_ok;

  assign write_ok   = write_sel   && addr_ok(32'(sel_write), DEPTH);
  assign reserve_ok = reserve_sel && addr_ok(32'(sel_reserve), DEPTH);

  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < DEPTH; r++) begin
      op[r] = BUSY_HOLD;
      if (write_ok && (32'(sel_write) == r))
        op[r] = BUSY_CLEAR;
      // The new producer wins over a retiring one on the same register.
      if (reserve_ok && (32'(sel_reserve) == r))
        op[r] = BUSY_SET;
      case (op[r])
        BUSY_CLEAR: busy_d[r] = 1'b0;
        BUSY_SET:   busy_d[r] = 1'b1;
        default:    busy_d[r] = busy_q[r];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

  // Post-edge view lets a same-cycle read observe this cycle's write/reserve.
  assign busy_next_o = busy_d;

endmodule

`default_nettype wire

// File: rtl/register_file_mp.sv
// register_file_mp: multi-port register file with registered reads, write bypass and busy scoreboard.
// ZERO_REG_EN: when defined, register 0 reads as zero and ignores writes/reserves.
`default_nettype none

module register_file_mp
  import register_file_mp_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_READ = DEF_NUM_READ
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       read_sel,
  input  logic [NUM_READ*ADDR_W-1:0] sel_read,
  output logic [NUM_READ*DATA_W-1:0] data_read,
  output logic [NUM_READ-1:0]        busy_read,
  input  logic                       write_sel,
  input  logic [ADDR_W-1:0]          sel_write,
  input  logic [DATA_W-1:0]          data_write,
  input  logic                       reserve_sel,
  input  logic [ADDR_W-1:0]          sel_reserve
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_next;
  logic              write_ok;

  assign write_ok = write_sel && addr_ok(32'(sel_write), DEPTH);

  reg_scoreboard #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .write_sel   (write_sel),
    .sel_write   (sel_write),
    .reserve_sel (reserve_sel),
    .sel_reserve (sel_reserve),
    .busy_next_o (busy_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++)
        mem_q[r] <= '0;
    end else if (write_ok) begin
      mem_q[sel_write] <= data_write;
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_read_port
    logic [ADDR_W-1:0] addr;
    logic              rd_ok;
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;
    logic              rbusy_d;
    logic              rbusy_q;

    assign addr  = sel_read[k*ADDR_W +: ADDR_W];
    assign rd_ok = addr_ok(32'(addr), DEPTH);

    always_comb begin
      rdata_d = DATA_W'(OOR_READ_VALUE);
      rbusy_d = 1'b0;
      if (rd_ok) begin
        rbusy_d = busy_next[addr];
        // Bypass: a write landing this edge is what the read must see.
        if (write_ok && (addr == sel_write))
          rdata_d = data_write;
        else
          rdata_d = mem_q[addr];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_q <= '0;
        rbusy_q <= 1'b0;
      end else if (read_sel) begin
        rdata_q <= rdata_d;
        rbusy_q <= rbusy_d;
      end
    end

    assign data_read[k*DATA_W +: DATA_W] = rdata_q;
    assign busy_read[k]                  = rbusy_q;
  end

endmodule

`default_nettype wire
